// File: rtl/disto_sched_pkg.sv
// Shared FSM encodings and constants for the distortion-engine scheduler.
// Watchdog constants exist only when DISTO_SCHED_TIMEOUT_EN is defined.
package disto_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int DISTO_SUM_W = 32;

`ifdef DISTO_SCHED_TIMEOUT_EN
  localparam int WDOG_W = 8;
  localparam logic [DISTO_SUM_W-1:0] DISTO_ERR_SUM = 32'hFFFF_FFFF;
`endif

  // Slot visited at offset off past the last grant, wrapping at n.
  function automatic int rr_slot(input int ptr, input int off, input int n);
    return (ptr + off) % n;
  endfunction

endpackage

// File: rtl/disto_sched_if.sv
// Requester, response and engine signals shared between the scheduler (slave)
// and the requester/engine side (master).
interface disto_sched_if #(
  parameter int N_REQ = 4
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [31:0]      rsp_sum;
  logic             rsp_err;
  logic             eng_start;
  logic [ID_W-1:0]  eng_sel;
  logic             eng_done;
  logic [31:0]      eng_sum;
  logic             spurious;

  modport master (
    output req_valid, rsp_ready, eng_done, eng_sum,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, eng_start, eng_sel, spurious
  );

  modport slave (
    input  req_valid, rsp_ready, eng_done, eng_sum,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_err, eng_start, eng_sel, spurious
  );
endinterface

// File: rtl/disto_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr+1 (mod N_REQ),
// returning a one-hot grant, its encoded id and an any-request flag.
module rr_arbiter
  import disto_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             any
);

  logic [ID_W-1:0] slot_s;
  logic            hit_s;

  // Scan slots in priority order; the first requesting slot wins.
  always_comb begin
    grant  = '0;
    id     = '0;
    any    = 1'b0;
    slot_s = '0;
    hit_s  = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      slot_s        = ID_W'(rr_slot(int'(ptr), off, N_REQ));
      hit_s         = !any && req[slot_s];
      grant[slot_s] = grant[slot_s] | hit_s;
      id            = hit_s ? slot_s : id;
      any           = any | hit_s;
    end
  end

endmodule

// File: rtl/disto_sched.sv
// Shares one weighted-distortion engine between N_REQ requesters, one job in flight.
// Optional WAIT watchdog enabled by defining DISTO_SCHED_TIMEOUT_EN.
module disto_sched
  import disto_sched_pkg::*;
#(
  parameter int N_REQ = 4
`ifdef DISTO_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input logic          clk,
  input logic          rst_n,
  disto_sched_if.slave bus
);

  localparam int ID_W = $clog2(N_REQ);

  state_t                 state_r;
  logic [ID_W-1:0]        ptr_r;
  logic [ID_W-1:0]        eng_sel_r;
  logic [ID_W-1:0]        rsp_id_r;
  logic [DISTO_SUM_W-1:0] rsp_sum_r;
  logic                   eng_start_r;
  logic                   rsp_valid_r;
  logic                   rsp_err_r;
  logic                   spurious_r;
  logic [N_REQ-1:0]       gnt_s;
  logic [N_REQ-1:0]       req_ready_s;
  logic [ID_W-1:0]        gnt_id_s;
  logic                   any_s;

`ifdef DISTO_SCHED_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);
  logic [WDOG_W-1:0] wdog_r;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .ptr   (ptr_r),
    .req   (bus.req_valid),
    .grant (gnt_s),
    .id    (gnt_id_s),
    .any   (any_s)
  );

  // Accept pulse is only offered while idle, so it lasts exactly the grant cycle.
  always_comb begin
    req_ready_s = '0;
    if (state_r == ST_IDLE) begin
      req_ready_s = gnt_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Scheduler FSM with registered engine and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= ID_W'(N_REQ - 1);
      eng_sel_r   <= '0;
      eng_start_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_sum_r   <= '0;
      rsp_err_r   <= 1'b0;
      spurious_r  <= 1'b0;
`ifdef DISTO_SCHED_TIMEOUT_EN
      wdog_r      <= '0;
`endif
    end else begin
      eng_start_r <= 1'b0;
      // A done pulse the FSM is not waiting for is flagged and otherwise dropped.
      if (bus.eng_done && (state_r != ST_WAIT)) begin
        spurious_r <= 1'b1;
      end else begin
        spurious_r <= spurious_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            eng_sel_r   <= gnt_id_s;
            ptr_r       <= gnt_id_s;
            eng_start_r <= 1'b1;
            state_r     <= ST_LAUNCH;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
`ifdef DISTO_SCHED_TIMEOUT_EN
          wdog_r  <= '0;
`endif
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.eng_done) begin
            rsp_sum_r   <= bus.eng_sum;
            rsp_id_r    <= eng_sel_r;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
`ifdef DISTO_SCHED_TIMEOUT_EN
          else if (wdog_r == WDOG_LAST) begin
            rsp_sum_r   <= DISTO_ERR_SUM;
            rsp_id_r    <= eng_sel_r;
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            wdog_r <= wdog_r + WDOG_W'(1);
          end
`else
          else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.eng_start = eng_start_r;
  assign bus.eng_sel   = eng_sel_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = rsp_sum_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.spurious  = spurious_r;

endmodule

// File: tb/tb_disto_sched.sv
// Directed + randomized bench for disto_sched; the engine and a round-robin
// reference model live here. Define DISTO_SCHED_TIMEOUT_EN to exercise the watchdog.
module tb_disto_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  disto_sched_if #(.N_REQ(4)) bus ();
  disto_sched #(.N_REQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  int          ptr_m;
  logic [3:0]  act;
  logic [31:0] sum_of [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: the valid requester closest after the last grant.
  function automatic int exp_grant(input int last, input logic [3:0] v);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + 8) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // One complete job: accept, start, engine latency lat, optional backpressure bp, handshake.
  task automatic job(input int g, input int lat, input int bp);
    logic [31:0] want;
    logic [3:0]  oh;
    want = sum_of[g];
    oh   = 4'b0001 << g;
    #1;
    chk("req_ready_grant", 32'(bus.req_ready), 32'(oh));
    tick();
    chk("eng_start_pulse", 32'(bus.eng_start), 32'd1);
    chk("eng_sel", 32'(bus.eng_sel), 32'(g));
    chk("req_ready_after", 32'(bus.req_ready), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk("eng_start_quiet", 32'(bus.eng_start), 32'd0);
      chk("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
    end
    bus.eng_done = 1'b1;
    bus.eng_sum  = sum_of[bus.eng_sel];
    tick();
    bus.eng_done = 1'b0;
    bus.eng_sum  = $urandom;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(g));
    chk("rsp_sum", bus.rsp_sum, want);
    chk("rsp_err", 32'(bus.rsp_err), 32'd0);
    for (int b = 0; b < bp; b++) begin
      tick();
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'(g));
      chk("bp_rsp_sum", bus.rsp_sum, want);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_eng_start", 32'(bus.eng_start), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int g;
    int i0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    bus.eng_done  = 1'b0;
    bus.eng_sum   = '0;
    act           = '0;
    ptr_m         = 3;
    repeat (3) tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_sum", bus.rsp_sum, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_eng_start", 32'(bus.eng_start), 32'd0);
    chk("rst_eng_sel", 32'(bus.eng_sel), 32'd0);
    chk("rst_spurious", 32'(bus.spurious), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: all four held, grants rotate from 0.
    act           = 4'b1111;
    bus.req_valid = act;
    for (int j = 0; j < 8; j++) begin
      sum_of[j % 4] = $urandom;
      job(j % 4, 20, 0);
    end
    ptr_m = 3;

    // Single job on requester 1, sum 1234, engine latency 20.
    act           = 4'b0010;
    bus.req_valid = act;
    sum_of[1]     = 32'd1234;
    job(1, 20, 0);
    ptr_m = 1;

    // Backpressure: response held 10 cycles.
    act           = 4'b1000;
    bus.req_valid = act;
    sum_of[3]     = $urandom;
    job(3, 20, 10);
    ptr_m = 3;
    act   = 4'b0000;

    // Randomized traffic against the reference arbitration model.
    for (int j = 0; j < 24; j++) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i] && ($urandom_range(0, 5) == 0)) act[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && ($urandom_range(0, 1) == 0)) begin
          act[i]    = 1'b1;
          sum_of[i] = $urandom;
        end
      end
      if (act == 4'b0000) begin
        i0         = int'($urandom_range(0, 3));
        act[i0]    = 1'b1;
        sum_of[i0] = $urandom;
      end
      bus.req_valid = act;
      g     = exp_grant(ptr_m, act);
      ptr_m = g;
      job(g, int'($urandom_range(16, 28)), int'($urandom_range(0, 3)));
      act[g]        = 1'b0;
      bus.req_valid = act;
    end
    act           = 4'b0000;
    bus.req_valid = act;
    tick();

    // Spurious done while idle.
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("spurious_set", 32'(bus.spurious), 32'd1);
    chk("spurious_no_rsp", 32'(bus.rsp_valid), 32'd0);
    repeat (5) tick();
    chk("spurious_sticky", 32'(bus.spurious), 32'd1);
    chk("spurious_no_rsp_late", 32'(bus.rsp_valid), 32'd0);

    // Reset five cycles after start aborts the job.
    bus.req_valid = 4'b0100;
    #1;
    chk("mid_req_ready", 32'(bus.req_ready), 32'd4);
    tick();
    chk("mid_eng_start", 32'(bus.eng_start), 32'd1);
    repeat (5) tick();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    ptr_m = 3;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_eng_start", 32'(bus.eng_start), 32'd0);
    chk("mid_rst_eng_sel", 32'(bus.eng_sel), 32'd0);
    chk("mid_rst_spurious", 32'(bus.spurious), 32'd0);
    chk("mid_rst_rsp_sum", bus.rsp_sum, 32'd0);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("late_done_spurious", 32'(bus.spurious), 32'd1);
    repeat (3) tick();
    chk("late_done_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Pointer restarts after reset.
    act           = 4'b0110;
    bus.req_valid = act;
    sum_of[1]     = $urandom;
    sum_of[2]     = $urandom;
    g             = exp_grant(ptr_m, act);
    ptr_m         = g;
    job(g, 18, 1);
    act           = 4'b0000;
    bus.req_valid = act;
    tick();

    // Engine never answers.
    bus.req_valid = 4'b0001;
    #1;
    chk("to_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("to_eng_start", 32'(bus.eng_start), 32'd1);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("to_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
`ifdef DISTO_SCHED_TIMEOUT_EN
    tick();
    chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("to_rsp_sum", bus.rsp_sum, 32'hFFFF_FFFF);
    chk("to_rsp_id", 32'(bus.rsp_id), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("to_rsp_drop", 32'(bus.rsp_valid), 32'd0);
`else
    repeat (16) tick();
    chk("to_off_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("to_off_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    bus.req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
